add_share_arbiter: RTL
======================

// Module: add_share_arbiter
// PURPOSE
//   Round-robin controller that time-shares one registered WIDTH-bit adder between two requesters.
//   Sequences each operation grant -> operand capture -> add -> result handshake.
//   Sits between the pin-level input groups and the sum datapath on uo_out.
// PARAMETERS
//   WIDTH  7  operand/sum width in bits (legal range >= 2)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   req        in   2      req[i]=1: requester i has operands ready; held until gnt[i] pulses
//   a0, b0     in   WIDTH  requester 0 operands; stable while req[0]=1
//   a1, b1     in   WIDTH  requester 1 operands; stable while req[1]=1
//   gnt        out  2      one-hot, 1-cycle pulse: operands of requester i captured this cycle
//   res_valid  out  1      result available; held until accepted
//   res_ready  in   1      consumer accepts result when res_valid & res_ready
//   res_sum    out  WIDTH  sum of the granted operands
//   res_carry  out  1      carry out of the WIDTH-bit add
//   res_id     out  1      index of the requester that owns res_sum
//   busy       out  1      1 in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE; gnt=0; res_valid=0; res_sum=0; res_carry=0; res_id=0; busy=0; last=1.
//   - FSM states: IDLE, LOAD, EXEC, RESP.
//   - IDLE:
//       - if req!=0: pick winner; win=the index != last when both requesters request, else the single requester.
//       - register win; go to LOAD. Stay in IDLE when req=0.
//   - LOAD:
//       - gnt[win]=1 for this cycle only.
//       - latch a_win/b_win into the operand registers; go to EXEC.
//   - EXEC:
//       - {carry,sum} = a+b, computed at WIDTH+1 bits and registered into res_*.
//       - res_id=win; go to RESP.
//   - RESP:
//       - res_valid=1; res_* stable.
//       - on res_valid&res_ready: clear res_valid, set last=win, go to IDLE (res_sum/res_carry/res_id keep their values).
//   - Latency: req seen in IDLE at cycle 0 -> gnt at cycle 1 -> res_valid at cycle 3.
//       - Minimum issue interval 4 cycles when res_ready is tied high.
//   - No new grant while in LOAD/EXEC/RESP; requests raised then wait, and are arbitrated in the next IDLE cycle.
//   - Wrap-around: the sum is modulo 2^WIDTH; the carry reports overflow (e.g. 7'h7F+7'h01 -> sum 0, carry 1).
//   - A req dropped after being sampled in IDLE is still granted; the operands on the bus in LOAD are used.
//   - Simultaneous res_ready with res_valid=0 has no effect.
//   - rst mid-operation (any state) -> IDLE next cycle:
//       - in-flight operands and result discarded, no gnt pulse.
//       - last=1, so requester 0 wins first after reset.
// CONFIGURATION
//   ADD_SHARE_SAT_EN defined:
//     - when carry=1, res_sum={WIDTH{1'b1}} (saturate); res_carry still reports overflow.
//   ADD_SHARE_SAT_EN undefined:
//     - res_sum = wrapped low WIDTH bits; latency identical.
// TESTING
//   1. rst=1 for 2 cycles, then req=2'b01, a0=5, b0=9, res_ready=1:
//      - gnt=01 at cycle 1; res_valid=1, res_sum=14, carry=0, id=0 at cycle 3; busy=0 at cycle 4.
//   2. req=2'b11 held continuously, res_ready=1: grants alternate 01,10,01,10 every 4 cycles, first grant to requester 0.
//   3. a1=7'h7F, b1=7'h01 on requester 1:
//      - without macro: res_sum=0, res_carry=1.
//      - with ADD_SHARE_SAT_EN: res_sum=7'h7F, res_carry=1.
//   4. res_ready=0 for 5 cycles after res_valid: res_valid and res_sum held; no gnt during the stall; completes the cycle after res_ready=1.
//   5. rst asserted during EXEC:
//      - next cycle all outputs 0, state IDLE.
//      - a later req=2'b11 is granted to requester 0 first.

Source files
------------

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder between two requesters.
// Optional saturation of the sum on overflow is enabled with `define ADD_SHARE_SAT_EN.
module add_share_arbiter #(
    parameter int WIDTH = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic [1:0]       o_gnt,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_res_sum,
    output logic             o_res_carry,
    output logic             o_res_id,
    output logic             o_busy
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

    state_t           r_state;
    logic             r_win;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_gnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_id;
    logic             r_busy;

    logic             w_win;
    logic [WIDTH:0]   w_full;
    logic [WIDTH-1:0] w_sum;

    // On contention the requester that did not finish last wins.
    assign w_win  = (i_req == 2'b11) ? ~r_last : i_req[1];
    assign w_full = {1'b0, r_a} + {1'b0, r_b};

`ifdef ADD_SHARE_SAT_EN
    assign w_sum = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
    assign w_sum = w_full[WIDTH-1:0];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_win   <= 1'b0;
            r_last  <= 1'b1;
            r_a     <= '0;
            r_b     <= '0;
            r_gnt   <= 2'b00;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_id    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req != 2'b00) begin
                        r_win   <= w_win;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // Operands come from the bus during the grant cycle, even if req dropped.
                    r_gnt   <= 2'b00;
                    r_a     <= r_win ? i_a1 : i_a0;
                    r_b     <= r_win ? i_b1 : i_b0;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_sum   <= w_sum;
                    r_carry <= w_full[WIDTH];
                    r_id    <= r_win;
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    if (r_valid && i_res_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= r_win;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_res_valid = r_valid;
    assign o_res_sum   = r_sum;
    assign o_res_carry = r_carry;
    assign o_res_id    = r_id;
    assign o_busy      = r_busy;

endmodule
